udt_rx_dispatcher: RTL and testbench

- Receive-side front end of the UDT core. Takes the UDP payload AXI-stream from the UDP/IP layer, decodes the UDT header in the first beat, and routes each whole packet to one of three streams.
- Handshake control packets go to the socket manager (`handshake_*` inputs). All other recognised control packets go to the control processor. Data packets go to the receive buffer.
- Emits a per-packet activity pulse that the socket manager uses to refresh LastRspTime.

---
 rtl/udt_pkg.sv | 36 +++
 rtl/udt_rx_dispatcher_if.sv | 14 +
 rtl/udt_hdr_decode.sv | 25 ++
 rtl/udt_rx_dispatcher.sv | 153 +++++++++++++++
 tb/tb_udt_rx_dispatcher.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/udt_pkg.sv
// Shared UDT definitions: control-type codes, routing destinations and the
// receive dispatcher FSM states.
package udt_pkg;

  localparam logic [14:0] UDT_CT_HANDSHAKE = 15'h0000;
  localparam logic [14:0] UDT_CT_KEEPALIVE = 15'h0001;
  localparam logic [14:0] UDT_CT_ACK       = 15'h0002;
  localparam logic [14:0] UDT_CT_NAK       = 15'h0003;
  localparam logic [14:0] UDT_CT_SHUTDOWN  = 15'h0005;
  localparam logic [14:0] UDT_CT_ACK2      = 15'h0006;
  localparam logic [14:0] UDT_CT_DROPREQ   = 15'h0007;
  localparam logic [14:0] UDT_CT_USERDEF   = 15'h7FFF;

  typedef enum logic [1:0] {
    DST_HS,
    DST_CTRL,
    DST_DATA,
    DST_DROP
  } udt_dst_e;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_FWD,
    ST_DROP
  } udt_rx_state_e;

  // Handshake is deliberately excluded: it has its own destination.
  function automatic logic is_ctrl_type(input logic [14:0] ct);
    case (ct)
      UDT_CT_KEEPALIVE, UDT_CT_ACK, UDT_CT_NAK, UDT_CT_SHUTDOWN,
      UDT_CT_ACK2, UDT_CT_DROPREQ, UDT_CT_USERDEF: is_ctrl_type = 1'b1;
      default:                                      is_ctrl_type = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/udt_rx_dispatcher_if.sv
// AXI-stream bundle used for the dispatcher input and its three output streams.
interface udt_rx_dispatcher_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udt_hdr_decode.sv
// Combinational classification of UDT header word 0 (upper half) and the
// header-word byte enables into a routing destination.
module udt_hdr_decode
  import udt_pkg::*;
(
  input  logic [15:0] w0_hi,
  input  logic [3:0]  keep_hi,
  output udt_dst_e    dst
);

  always_comb begin
    dst = DST_DROP;
    // A header whose first word is not fully present cannot be trusted.
    if (keep_hi != 4'hF) begin
      dst = DST_DROP;
    end else if (!w0_hi[15]) begin
      dst = DST_DATA;
    end else if (w0_hi[14:0] == UDT_CT_HANDSHAKE) begin
      dst = DST_HS;
    end else if (is_ctrl_type(w0_hi[14:0])) begin
      dst = DST_CTRL;
    end
  end

endmodule

// File: rtl/udt_rx_dispatcher.sv
// UDT receive dispatcher: routes whole packets to handshake, control or data
// streams through one shared output slice. Optional stats: UDT_RX_STATS_EN.
module udt_rx_dispatcher
  import udt_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int KEEP_W     = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  core_clk,
  input  logic                  core_rst_n,
  udt_rx_dispatcher_if.slave    rx,
  udt_rx_dispatcher_if.master   handshake,
  udt_rx_dispatcher_if.master   ctrl,
  udt_rx_dispatcher_if.master   data,
  output logic [14:0]           ctrl_type,
  output logic                  rsp_pulse,
`ifdef UDT_RX_STATS_EN
  output logic [31:0]           hs_cnt,
  output logic [31:0]           ctrl_cnt,
  output logic [31:0]           data_cnt,
`endif
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  udt_rx_state_e     state_q, state_d;
  udt_dst_e          fwd_dst_q;
  udt_dst_e          hdr_dst_p0;
  udt_dst_e          beat_dst_p0;

  logic              vld_p1;
  udt_dst_e          dst_p1;
  logic [DATA_W-1:0] tdata_p1;
  logic [KEEP_W-1:0] tkeep_p1;
  logic              tlast_p1;

  logic              dest_tready;
  logic              slice_rdy;
  logic              accept_p0;
  logic              hdr_acc_p0;
  logic              load_p0;

  udt_hdr_decode u_hdr_decode (
    .w0_hi   (rx.tdata[63:48]),
    .keep_hi (rx.tkeep[7:4]),
    .dst     (hdr_dst_p0)
  );

  // Input stage: pick destination for this beat and decide accept/load.
  assign beat_dst_p0 = (state_q == ST_HDR) ? hdr_dst_p0 : fwd_dst_q;

  always_comb begin
    dest_tready = 1'b1;
    case (dst_p1)
      DST_HS:   dest_tready = handshake.tready;
      DST_CTRL: dest_tready = ctrl.tready;
      DST_DATA: dest_tready = data.tready;
      default:  dest_tready = 1'b1;
    endcase
  end

  assign slice_rdy  = !vld_p1 || dest_tready;
  assign rx.tready  = (state_q == ST_DROP) || slice_rdy;
  assign accept_p0  = rx.tvalid && rx.tready;
  assign hdr_acc_p0 = accept_p0 && (state_q == ST_HDR);
  assign load_p0    = accept_p0 && (state_q != ST_DROP) && (beat_dst_p0 != DST_DROP);

  always_comb begin
    state_d = state_q;
    if (accept_p0) begin
      case (state_q)
        ST_HDR: begin
          if (!rx.tlast) state_d = (hdr_dst_p0 == DST_DROP) ? ST_DROP : ST_FWD;
        end
        ST_FWD, ST_DROP: begin
          if (rx.tlast) state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q   <= ST_HDR;
      fwd_dst_q <= DST_DROP;
    end else begin
      state_q <= state_d;
      if (hdr_acc_p0) fwd_dst_q <= hdr_dst_p0;
    end
  end

  // Output slice stage: loads and unloads in the same cycle at full rate.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      vld_p1   <= 1'b0;
      dst_p1   <= DST_DROP;
      tdata_p1 <= '0;
      tkeep_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else if (load_p0) begin
      vld_p1   <= 1'b1;
      dst_p1   <= beat_dst_p0;
      tdata_p1 <= rx.tdata;
      tkeep_p1 <= rx.tkeep;
      tlast_p1 <= rx.tlast;
    end else if (vld_p1 && dest_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rsp_pulse <= 1'b0;
      drop_cnt  <= '0;
      ctrl_type <= '0;
    end else begin
      rsp_pulse <= hdr_acc_p0 && (hdr_dst_p0 != DST_DROP);
      if (hdr_acc_p0 && (hdr_dst_p0 == DST_DROP)) drop_cnt <= drop_cnt + 1'b1;
      if (hdr_acc_p0 && (hdr_dst_p0 == DST_CTRL)) ctrl_type <= rx.tdata[62:48];
    end
  end

`ifdef UDT_RX_STATS_EN
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      hs_cnt   <= '0;
      ctrl_cnt <= '0;
      data_cnt <= '0;
    end else if (hdr_acc_p0) begin
      if (hdr_dst_p0 == DST_HS)   hs_cnt   <= hs_cnt + 32'd1;
      if (hdr_dst_p0 == DST_CTRL) ctrl_cnt <= ctrl_cnt + 32'd1;
      if (hdr_dst_p0 == DST_DATA) data_cnt <= data_cnt + 32'd1;
    end
  end
`endif

  assign handshake.tvalid = vld_p1 && (dst_p1 == DST_HS);
  assign handshake.tdata  = tdata_p1;
  assign handshake.tkeep  = tkeep_p1;
  assign handshake.tlast  = tlast_p1;

  assign ctrl.tvalid = vld_p1 && (dst_p1 == DST_CTRL);
  assign ctrl.tdata  = tdata_p1;
  assign ctrl.tkeep  = tkeep_p1;
  assign ctrl.tlast  = tlast_p1;

  assign data.tvalid = vld_p1 && (dst_p1 == DST_DATA);
  assign data.tdata  = tdata_p1;
  assign data.tkeep  = tkeep_p1;
  assign data.tlast  = tlast_p1;

endmodule

// File: tb/tb_udt_rx_dispatcher.sv
// Directed bench for udt_rx_dispatcher; builds with or without UDT_RX_STATS_EN.
module tb_udt_rx_dispatcher;

  logic core_clk = 1'b0;
  logic core_rst_n;
  always #5 core_clk = ~core_clk;

  udt_rx_dispatcher_if #(.DATA_W(64), .KEEP_W(8)) rx_if ();
  udt_rx_dispatcher_if #(.DATA_W(64), .KEEP_W(8)) hs_if ();
  udt_rx_dispatcher_if #(.DATA_W(64), .KEEP_W(8)) ctrl_if ();
  udt_rx_dispatcher_if #(.DATA_W(64), .KEEP_W(8)) data_if ();

  logic [14:0] ctrl_type;
  logic        rsp_pulse;
  logic [15:0] drop_cnt;
`ifdef UDT_RX_STATS_EN
  logic [31:0] hs_cnt, ctrl_cnt, data_cnt;
`endif

  udt_rx_dispatcher #(.DATA_W(64), .KEEP_W(8), .DROP_CNT_W(16)) dut (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .rx         (rx_if),
    .handshake  (hs_if),
    .ctrl       (ctrl_if),
    .data       (data_if),
    .ctrl_type  (ctrl_type),
    .rsp_pulse  (rsp_pulse),
`ifdef UDT_RX_STATS_EN
    .hs_cnt     (hs_cnt),
    .ctrl_cnt   (ctrl_cnt),
    .data_cnt   (data_cnt),
`endif
    .drop_cnt   (drop_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int stall    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and return #1 after the edge on which it was accepted.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    rx_if.tdata  = d;
    rx_if.tkeep  = k;
    rx_if.tlast  = l;
    rx_if.tvalid = 1'b1;
    while (!done) begin
      @(negedge core_clk);
      if (rx_if.tready) begin
        @(posedge core_clk);
        #1;
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          checks++;
          failures++;
          $display("FAIL send_timeout observed=stalled expected=accept data=%0h", d);
          done = 1'b1;
        end
      end
    end
    stall = n;
  endtask

  task automatic idle();
    rx_if.tvalid = 1'b0;
    @(posedge core_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    core_rst_n      = 1'b0;
    rx_if.tdata     = '0;
    rx_if.tkeep     = '0;
    rx_if.tlast     = 1'b0;
    rx_if.tvalid    = 1'b0;
    hs_if.tready    = 1'b1;
    ctrl_if.tready  = 1'b1;
    data_if.tready  = 1'b1;
    repeat (3) @(posedge core_clk);
    #1;
    core_rst_n = 1'b1;
    @(posedge core_clk);
    #1;

    // Reset state
    chk("rst_hs_tvalid", hs_if.tvalid, 0);
    chk("rst_ctrl_tvalid", ctrl_if.tvalid, 0);
    chk("rst_data_tvalid", data_if.tvalid, 0);
    chk("rst_data_tdata", data_if.tdata, 0);
    chk("rst_rsp", rsp_pulse, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ctrl_type", ctrl_type, 0);
    chk("rst_rx_tready", rx_if.tready, 1);

    // Single-beat handshake
    send(64'h8000_0000_DEAD_BEEF, 8'hFF, 1'b1);
    chk("hs1_tvalid", hs_if.tvalid, 1);
    chk("hs1_tdata", hs_if.tdata, 64'h8000_0000_DEAD_BEEF);
    chk("hs1_tkeep", hs_if.tkeep, 8'hFF);
    chk("hs1_tlast", hs_if.tlast, 1);
    chk("hs1_rsp", rsp_pulse, 1);
    chk("hs1_ctrl_tvalid", ctrl_if.tvalid, 0);
    chk("hs1_data_tvalid", data_if.tvalid, 0);
    idle();
    chk("hs1_rsp_off", rsp_pulse, 0);
    chk("hs1_tvalid_off", hs_if.tvalid, 0);
    chk("hs1_drop", drop_cnt, 0);

    // 3-beat data packet
    for (int i = 1; i <= 3; i++) begin
      send({32'h0000_1234, 32'(i)}, 8'hFF, (i == 3));
      chk("dat_tvalid", data_if.tvalid, 1);
      chk("dat_tdata", data_if.tdata, {32'h0000_1234, 32'(i)});
      chk("dat_tlast", data_if.tlast, (i == 3));
      chk("dat_hs_tvalid", hs_if.tvalid, 0);
      chk("dat_ctrl_tvalid", ctrl_if.tvalid, 0);
      chk("dat_rsp", rsp_pulse, (i == 1));
      chk("dat_stall", stall, 0);
    end
    idle();
    chk("dat_tvalid_off", data_if.tvalid, 0);

    // ACK packet with ctrl stalled for 5 cycles
    ctrl_if.tready = 1'b0;
    send(64'h8002_0000_AAAA_0001, 8'hFF, 1'b0);
    chk("ack_tvalid", ctrl_if.tvalid, 1);
    chk("ack_ctrl_type", ctrl_type, 15'd2);
    chk("ack_rsp", rsp_pulse, 1);
    rx_if.tdata = 64'h1111_2222_3333_4444;
    rx_if.tkeep = 8'hF0;
    rx_if.tlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      chk("ack_stall_rx_tready", rx_if.tready, 0);
      chk("ack_stall_tvalid", ctrl_if.tvalid, 1);
      chk("ack_stall_tdata", ctrl_if.tdata, 64'h8002_0000_AAAA_0001);
      chk("ack_stall_tlast", ctrl_if.tlast, 0);
    end
    ctrl_if.tready = 1'b1;
    @(posedge core_clk);
    #1;
    chk("ack_b2_tvalid", ctrl_if.tvalid, 1);
    chk("ack_b2_tdata", ctrl_if.tdata, 64'h1111_2222_3333_4444);
    chk("ack_b2_tkeep", ctrl_if.tkeep, 8'hF0);
    chk("ack_b2_tlast", ctrl_if.tlast, 1);
    idle();
    chk("ack_tvalid_off", ctrl_if.tvalid, 0);
    chk("ack_ctrl_type_hold", ctrl_type, 15'd2);

    // Unknown type 4 (2 beats) then a runt header
    send(64'h8004_0000_0000_0000, 8'hFF, 1'b0);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_rsp", rsp_pulse, 0);
    chk("t4_ctrl_tvalid", ctrl_if.tvalid, 0);
    chk("t4_hs_tvalid", hs_if.tvalid, 0);
    send(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    chk("t4_b2_stall", stall, 0);
    chk("t4_b2_data_tvalid", data_if.tvalid, 0);
    chk("t4_b2_ctrl_tvalid", ctrl_if.tvalid, 0);
    send(64'h0000_0001_0000_0000, 8'h0F, 1'b1);
    chk("runt_stall", stall, 0);
    chk("runt_drop", drop_cnt, 2);
    chk("runt_data_tvalid", data_if.tvalid, 0);
    chk("runt_rsp", rsp_pulse, 0);
    idle();
    chk("drop_ctrl_type_hold", ctrl_type, 15'd2);

    // Back-to-back HS, DATA, CTRL(keepalive), CTRL(userdef), dropped type 8
    send(64'h8000_0000_0000_00A1, 8'hFF, 1'b1);
    chk("b2b_hs_tvalid", hs_if.tvalid, 1);
    chk("b2b_hs_tdata", hs_if.tdata, 64'h8000_0000_0000_00A1);
    chk("b2b_hs_stall", stall, 0);
    send(64'h0000_0055_0000_00B2, 8'hFF, 1'b1);
    chk("b2b_dat_tvalid", data_if.tvalid, 1);
    chk("b2b_dat_hs_tvalid", hs_if.tvalid, 0);
    chk("b2b_dat_tdata", data_if.tdata, 64'h0000_0055_0000_00B2);
    chk("b2b_dat_stall", stall, 0);
    chk("b2b_dat_rsp", rsp_pulse, 1);
    send(64'h8001_0000_0000_00C3, 8'hFF, 1'b1);
    chk("b2b_ka_tvalid", ctrl_if.tvalid, 1);
    chk("b2b_ka_data_tvalid", data_if.tvalid, 0);
    chk("b2b_ka_ctrl_type", ctrl_type, 15'd1);
    chk("b2b_ka_stall", stall, 0);
    send(64'hFFFF_0000_0000_00D4, 8'hFF, 1'b1);
    chk("b2b_ud_tvalid", ctrl_if.tvalid, 1);
    chk("b2b_ud_tdata", ctrl_if.tdata, 64'hFFFF_0000_0000_00D4);
    chk("b2b_ud_ctrl_type", ctrl_type, 15'h7FFF);
    chk("b2b_ud_stall", stall, 0);
    send(64'h8008_0000_0000_00E5, 8'hFF, 1'b1);
    chk("b2b_t8_ctrl_tvalid", ctrl_if.tvalid, 0);
    chk("b2b_t8_drop", drop_cnt, 3);
    chk("b2b_t8_rsp", rsp_pulse, 0);
    chk("b2b_t8_ctrl_type", ctrl_type, 15'h7FFF);
    chk("b2b_t8_stall", stall, 0);
    idle();
`ifdef UDT_RX_STATS_EN
    chk("stats_hs", hs_cnt, 2);
    chk("stats_ctrl", ctrl_cnt, 3);
    chk("stats_data", data_cnt, 2);
`endif

    // Reset in the middle of a 4-beat data packet
    send(64'h0000_0777_0000_0001, 8'hFF, 1'b0);
    send(64'h0000_0777_0000_0002, 8'hFF, 1'b0);
    chk("mid_data_tvalid", data_if.tvalid, 1);
    rx_if.tvalid = 1'b0;
    #2;
    core_rst_n = 1'b0;
    #1;
    chk("mid_rst_data_tvalid", data_if.tvalid, 0);
    chk("mid_rst_data_tdata", data_if.tdata, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_ctrl_type", ctrl_type, 0);
    chk("mid_rst_rsp", rsp_pulse, 0);
    @(posedge core_clk);
    #1;
    core_rst_n = 1'b1;
    send(64'h8000_0000_0000_00F6, 8'hFF, 1'b1);
    chk("post_rst_hs_tvalid", hs_if.tvalid, 1);
    chk("post_rst_hs_tdata", hs_if.tdata, 64'h8000_0000_0000_00F6);
    chk("post_rst_data_tvalid", data_if.tvalid, 0);
    chk("post_rst_rsp", rsp_pulse, 1);
    idle();
    chk("post_rst_hs_off", hs_if.tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
